bist_run_controller: RTL
========================

Name: bist_run_controller

Overview:
- Sequencer and response analyser placed directly downstream of the LFSR/ALU/ROM BIST core.
- Drives the core's active-high `reset` and 4-bit `ALU_Sel`, and consumes the core's per-cycle `match` output.
- Sweeps the core through every ALU opcode, or a single selected one, for one full ROM pass each. Counts mismatches and reports pass/fail through a start/busy/done handshake.

Parameters:
- PATTERNS, 256, cycles sampled per opcode; equals the core ROM depth (address wraps at 256).
- NUM_OPS, 16, number of opcodes swept in full mode (0..NUM_OPS-1).
- ERR_W, 16, width of the mismatch counter.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin a run; sampled only in IDLE
- single_op  input  1  1 = test only start_op; 0 = sweep all opcodes; sampled with start
- start_op  input  4  opcode for single-op mode; sampled with start
- match  input  1  core compare result for the current pattern
- core_reset  output  1  active-high reset to the BIST core
- alu_sel  output  4  opcode driven to the core ALU_Sel
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  sticky; high in DONE until the next accepted start
- pass  output  1  valid when done; 1 iff err_count == 0
- err_count  output  ERR_W  saturating mismatch count for the run
- first_fail_op  output  4  opcode of the first mismatch (feature-dependent)
- first_fail_addr  output  8  pattern index of the first mismatch (feature-dependent)

Behaviour:
- Reset values (reset_n low, asynchronous): state = IDLE, core_reset = 1, alu_sel = 0, busy = 0, done = 0, pass = 0, err_count = 0, first_fail_* = 0.
- States:
  - IDLE: start=1 → ARM. Latch single_op. Op register = (single_op ? start_op : 0). Clear err_count, first_fail_*, done.
  - ARM: exactly one cycle. core_reset = 1; alu_sel = op register. Next state RUN; pat_cnt = 0.
  - RUN: core_reset = 0. At each rising edge, sample match for the current pat_cnt.
    - match == 0: err_count += 1, saturating at all-ones.
    - At pat_cnt == PATTERNS-1: if single_op, or op == NUM_OPS-1 → DONE; else op += 1 → ARM. Otherwise pat_cnt += 1.
  - DONE: core_reset = 1; busy = 0; done = 1; pass = (err_count == 0). start=1 → ARM, with the same latching as in IDLE.
- core_reset is decoded from the state register only, never from inputs. It is low only in RUN.
- pat_cnt tracks the core ROM address exactly. The core address is 0 in the first RUN cycle because core_reset was high during ARM.
- Latency:
  - Per opcode: PATTERNS+1 cycles.
  - done rises NUM_OPS*(PATTERNS+1) = 4112 cycles after the edge that accepts start (full mode).
  - Single-op mode: PATTERNS+1 = 257 cycles.
- busy: high in ARM and RUN.
- start asserted while busy: ignored.
- alu_sel: stable throughout ARM and RUN of a given opcode.
- Opcode increment is 4-bit. No wrap occurs, because the sweep ends at NUM_OPS-1.
- reset_n low mid-run: immediate return to IDLE with all outputs at reset values. There is no resume.
- match is ignored in IDLE, ARM and DONE.

Optional Feature:
- BIST_FAIL_LOG_EN defined:
  - first_fail_op and first_fail_addr capture {op, pat_cnt} on the first mismatch of a run.
  - They hold that value until the next accepted start.
- Not defined: both ports tied to 0 and the capture registers are not built.

Decomposition:
- Shared package bist_pkg:
  - state enum {IDLE, ARM, RUN, DONE}
  - localparams for ROM depth (256), opcode width (4) and address width (8)
- One natural sub-module: bist_err_counter. It is a saturating ERR_W counter with clear and inc inputs, instantiated once.

Test Plan:
- match tied 1, full mode, start pulse:
  - done rises exactly 4112 cycles after the start edge; pass = 1; err_count = 0.
  - alu_sel steps 0..15, each held for 257 cycles.
- match tied 0, full mode:
  - err_count = 4096 (0x1000); pass = 0.
  - With BIST_FAIL_LOG_EN: first_fail_op = 0, first_fail_addr = 0.
- match driven low only at op 3, pat_cnt 5 and op 9, pat_cnt 200:
  - err_count = 2; pass = 0.
  - With BIST_FAIL_LOG_EN: first_fail_op = 3, first_fail_addr = 5.
- single_op = 1, start_op = 7, match tied 1:
  - alu_sel = 7 throughout; done after 257 cycles; core_reset low for exactly 256 cycles.
- Reset and start handling:
  - reset_n pulsed low at cycle 1000 of a full run: all outputs return to reset values immediately (core_reset = 1, busy = 0); a subsequent start runs cleanly.
  - start re-pulsed while busy: no effect on timing or counts.

Source files
------------

// File: rtl/bist_pkg.sv
// -----------------------------------------------------------------------------
// bist_pkg
// Shared definitions for the BIST run controller slice:
//   - bist_state_e : sequencer states (IDLE, ARM, RUN, DONE)
//   - ROM_DEPTH    : depth of the BIST core pattern ROM
//   - OP_W         : ALU opcode width
//   - ADDR_W       : pattern (ROM address) index width
// -----------------------------------------------------------------------------
package bist_pkg;

    localparam int unsigned ROM_DEPTH = 256;
    localparam int unsigned OP_W      = 4;
    localparam int unsigned ADDR_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } bist_state_e;

endpackage : bist_pkg

// File: rtl/bist_err_counter.sv
// -----------------------------------------------------------------------------
// bist_err_counter
// Saturating mismatch counter. Clear has priority over increment; once the
// count reaches all-ones it holds there until cleared.
// Ports:
//   clk_i    : clock, rising edge
//   rst_n_i  : asynchronous active-low reset
//   clr_i    : synchronous clear to zero
//   inc_i    : increment request (ignored at saturation)
//   count_o  : current count
// -----------------------------------------------------------------------------
module bist_err_counter #(
    parameter int ERR_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [ERR_W-1:0] count_o
);

    localparam logic [ERR_W-1:0] CNT_ZERO = {ERR_W{1'b0}};
    localparam logic [ERR_W-1:0] CNT_MAX  = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] CNT_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};

    logic [ERR_W-1:0] count_q;

    // Count register: clear, saturating increment, or hold.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= CNT_ZERO;
        end else if (clr_i) begin
            count_q <= CNT_ZERO;
        end else if (inc_i && (count_q != CNT_MAX)) begin
            count_q <= count_q + CNT_ONE;
        end else begin
            count_q <= count_q;
        end
    end

    assign count_o = count_q;

endmodule : bist_err_counter

// File: rtl/bist_run_controller.sv
// -----------------------------------------------------------------------------
// bist_run_controller
// Sequencer and response analyser for the LFSR/ALU/ROM BIST core. Sweeps the
// core through all opcodes (or one selected opcode), one full ROM pass each,
// counts mismatches and reports pass/fail via start/busy/done.
//
// Optional feature macro: BIST_FAIL_LOG_EN
//   defined   : first_fail_op/first_fail_addr capture {op, pattern} of the
//               first mismatch of a run and hold it until the next start.
//   undefined : both ports are tied to zero, no capture registers exist.
//
// Ports:
//   clk             : system clock, rising edge
//   reset_n         : asynchronous active-low reset
//   start           : run request, accepted in IDLE or DONE only
//   single_op       : 1 = test only start_op, 0 = sweep all opcodes
//   start_op        : opcode for single-op mode
//   match           : core compare result for the current pattern
//   core_reset      : active-high reset to the BIST core (low only in RUN)
//   alu_sel         : opcode driven to the core
//   busy            : high in ARM and RUN
//   done            : high in DONE
//   pass            : valid with done; 1 iff err_count == 0
//   err_count       : saturating mismatch count for the run
//   first_fail_op   : opcode of the first mismatch (feature-dependent)
//   first_fail_addr : pattern index of the first mismatch (feature-dependent)
// -----------------------------------------------------------------------------
module bist_run_controller
    import bist_pkg::*;
#(
    parameter int PATTERNS = ROM_DEPTH,
    parameter int NUM_OPS  = 16,
    parameter int ERR_W    = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                single_op,
    input  logic [OP_W-1:0]     start_op,
    input  logic                match,
    output logic                core_reset,
    output logic [OP_W-1:0]     alu_sel,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ERR_W-1:0]    err_count,
    output logic [OP_W-1:0]     first_fail_op,
    output logic [ADDR_W-1:0]   first_fail_addr
);

    localparam logic [ADDR_W-1:0] LAST_PAT = ADDR_W'(PATTERNS - 1);
    localparam logic [OP_W-1:0]   LAST_OP  = OP_W'(NUM_OPS - 1);
    localparam logic [ADDR_W-1:0] PAT_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] PAT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [OP_W-1:0]   OP_ZERO  = {OP_W{1'b0}};
    localparam logic [OP_W-1:0]   OP_ONE   = {{(OP_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0]  ERR_ZERO = {ERR_W{1'b0}};

    bist_state_e        state_q,  state_d;
    logic [OP_W-1:0]    op_q,     op_d;
    logic [ADDR_W-1:0]  pat_q,    pat_d;
    logic               single_q, single_d;
    logic               clr_s;
    logic               inc_s;
    logic [ERR_W-1:0]   err_cnt_s;

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            op_q     <= OP_ZERO;
            pat_q    <= PAT_ZERO;
            single_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            pat_q    <= pat_d;
            single_q <= single_d;
        end
    end

    // Next-state logic: start acceptance, opcode stepping, pattern counting.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        pat_d    = pat_q;
        single_d = single_q;
        clr_s    = 1'b0;
        inc_s    = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = ARM;
                    single_d = single_op;
                    op_d     = single_op ? start_op : OP_ZERO;
                    clr_s    = 1'b1;
                end else begin
                    state_d  = state_q;
                end
            end

            ARM: begin
                // Core is held in reset here, so its ROM address is 0 on the
                // first RUN cycle; pat_q mirrors that.
                state_d = RUN;
                pat_d   = PAT_ZERO;
            end

            RUN: begin
                inc_s = ~match;
                if (pat_q == LAST_PAT) begin
                    pat_d = PAT_ZERO;
                    if (single_q || (op_q == LAST_OP)) begin
                        state_d = DONE;
                    end else begin
                        op_d    = op_q + OP_ONE;
                        state_d = ARM;
                    end
                end else begin
                    pat_d = pat_q + PAT_ONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    bist_err_counter #(
        .ERR_W (ERR_W)
    ) u_err_counter (
        .clk_i   (clk),
        .rst_n_i (reset_n),
        .clr_i   (clr_s),
        .inc_i   (inc_s),
        .count_o (err_cnt_s)
    );

`ifdef BIST_FAIL_LOG_EN
    logic               fail_seen_q;
    logic [OP_W-1:0]    ff_op_q;
    logic [ADDR_W-1:0]  ff_addr_q;

    // First-failure capture: cleared on accepted start, loaded once per run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fail_seen_q <= 1'b0;
            ff_op_q     <= OP_ZERO;
            ff_addr_q   <= PAT_ZERO;
        end else if (clr_s) begin
            fail_seen_q <= 1'b0;
            ff_op_q     <= OP_ZERO;
            ff_addr_q   <= PAT_ZERO;
        end else if ((state_q == RUN) && !match && !fail_seen_q) begin
            fail_seen_q <= 1'b1;
            ff_op_q     <= op_q;
            ff_addr_q   <= pat_q;
        end else begin
            fail_seen_q <= fail_seen_q;
            ff_op_q     <= ff_op_q;
            ff_addr_q   <= ff_addr_q;
        end
    end

    assign first_fail_op   = ff_op_q;
    assign first_fail_addr = ff_addr_q;
`else
    assign first_fail_op   = OP_ZERO;
    assign first_fail_addr = PAT_ZERO;
`endif

    // Outputs are decoded from registered state only, never from inputs.
    assign core_reset = (state_q != RUN);
    assign busy       = (state_q == ARM) || (state_q == RUN);
    assign done       = (state_q == DONE);
    assign pass       = (state_q == DONE) && (err_cnt_s == ERR_ZERO);
    assign alu_sel    = op_q;
    assign err_count  = err_cnt_s;

endmodule : bist_run_controller
